// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_flex
// Brief    : Single-clock FIFO with selectable standard / first-word-fall-
//            through read mode, almost-full / almost-empty thresholds,
//            occupancy count, synchronous flush and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_flex #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FWFT       = 0,
   parameter int AF_LEVEL   = 12,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_wr_en,
   input  logic [DATA_WIDTH-1:0] io_wdata,
   input  logic                  io_rd_en,
   output logic [DATA_WIDTH-1:0] io_rdata,
   output logic                  io_rvalid,
   input  logic                  io_flush,
   input  logic                  io_clr_err,
   output logic                  io_full,
   output logic                  io_empty,
   output logic                  io_almost_full,
   output logic                  io_almost_empty,
   output logic [ADDR_WIDTH:0]   io_count,
   output logic                  io_overflow,
   output logic                  io_underflow
);

   localparam int unsigned           c_DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   c_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
   localparam logic [ADDR_WIDTH:0]   c_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic                  r_overflow;
   logic                  r_underflow;

   logic [ADDR_WIDTH:0]   w_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_accept;
   logic                  w_rd_accept;
   logic                  w_wr_drop;
   logic                  w_rd_reject;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [ADDR_WIDTH-1:0] w_rd_addr;

   // Status derived purely from registered pointers; the extra MSB is the wrap bit.
   assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
   assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];
   assign w_count   = r_wr_ptr - r_rd_ptr;
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (w_wr_addr == w_rd_addr) &&
                      (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

   // Flush takes priority over both requests and suppresses error reporting.
   assign w_wr_accept = io_wr_en && !w_full  && !io_flush;
   assign w_rd_accept = io_rd_en && !w_empty && !io_flush;
   assign w_wr_drop   = io_wr_en &&  w_full  && !io_flush;
   assign w_rd_reject = io_rd_en &&  w_empty && !io_flush;

   assign io_count        = w_count;
   assign io_empty        = w_empty;
   assign io_full         = w_full;
   assign io_almost_full  = (w_count >= c_AF);
   assign io_almost_empty = (w_count <= c_AE);
   assign io_overflow     = r_overflow;
   assign io_underflow    = r_underflow;

   // Storage array: no reset, contents survive flush and are simply unreachable.
   always_ff @(posedge clock) begin
      if (!reset && w_wr_accept) begin
         r_mem[w_wr_addr] <= io_wdata;
      end
   end

   // Pointer update; flush rewinds both pointers to zero.
   always_ff @(posedge clock) begin
      if (reset || io_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_accept) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   // Sticky error flags: a new error in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (io_clr_err) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end
         if (w_wr_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_rd_reject) begin
            r_underflow <= 1'b1;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head entry is presented continuously; a read acknowledges it.
         assign io_rdata  = r_mem[w_rd_addr];
         assign io_rvalid = !w_empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_rdata;
         logic                  r_rvalid;

         // Registered read: popped word appears for exactly one cycle after the pop.
         always_ff @(posedge clock) begin
            if (reset) begin
               r_rdata  <= '0;
               r_rvalid <= 1'b0;
            end else begin
               r_rvalid <= w_rd_accept;
               if (w_rd_accept) begin
                  r_rdata <= r_mem[w_rd_addr];
               end
            end
         end

         assign io_rdata  = r_rdata;
         assign io_rvalid = r_rvalid;
      end
   endgenerate

endmodule
`default_nettype wire

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO: the next generation of our FIFO family, with configurable depth and width, selectable standard or first-word-fall-through read mode, programmable almost-full and almost-empty thresholds, an occupancy count, synchronous flush and sticky overflow/underflow flags. Used wherever producer and consumer share one clock: stream buffering between pipeline stages, and the same-clock side of bridges that were previously built on the asynchronous FIFO.

## Interface
- DATA_WIDTH, 8, width of each entry
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2^ADDR_WIDTH (16)
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
- AF_LEVEL, 12, almost-full asserts when count >= AF_LEVEL; legal range 1..DEPTH
- AE_LEVEL, 2, almost-empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1

- clock  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- io_wr_en  in  1  write request
- io_wdata  in  DATA_WIDTH  write data
- io_rd_en  in  1  read request (pop)
- io_rdata  out  DATA_WIDTH  read data
- io_rvalid  out  1  io_rdata holds valid popped data (standard) or head entry (FWFT)
- io_flush  in  1  synchronous discard of all contents
- io_clr_err  in  1  clears sticky error flags
- io_full, io_empty, io_almost_full, io_almost_empty  out  1  status flags
- io_count  out  ADDR_WIDTH+1  entries stored, 0..DEPTH
- io_overflow, io_underflow  out  1  sticky error flags

## Operation
- Storage: DEPTH x DATA_WIDTH array; write and read pointers ADDR_WIDTH+1 bits wide, MSB acts as wrap bit. full = (addr bits equal, wrap bits differ); empty = pointers equal. count = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Write accepted iff io_wr_en && !io_full: mem[wr_ptr] <= io_wdata, wr_ptr += 1.
- Read accepted iff io_rd_en && !io_empty: rd_ptr += 1.
- Full/empty are evaluated on pre-edge state: write while full is dropped even if a read is accepted in the same cycle; read while empty is rejected even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Dropped write sets io_overflow; rejected read sets io_underflow. Both stay set until reset or io_clr_err. If io_clr_err and a new error occur in the same cycle, the flag stays set (set wins).
- io_flush: both pointers <= 0 and count -> 0. Overrides io_wr_en and io_rd_en in the same cycle: nothing is written, nothing is popped, and no error flags are set. Stored data is not cleared. Standard mode: io_rvalid <= 0.
- Standard mode (FWFT=0): an accepted read loads io_rdata <= mem[rd_ptr] and sets io_rvalid = 1 for exactly the following cycle. Otherwise io_rvalid = 0 and io_rdata holds its last value.
- FWFT mode (FWFT=1): io_rdata = mem[rd_ptr] combinationally from registered state; io_rvalid = !io_empty; io_rd_en acknowledges (pops) the displayed word.
- Pointers wrap naturally at 2^(ADDR_WIDTH+1); no special handling is needed.

## Timing
- Reset: pointers = 0, io_count = 0, io_empty = 1, io_full = 0, io_almost_empty = 1 (count 0 <= AE_LEVEL), io_almost_full = 0, io_overflow = io_underflow = 0, io_rvalid = 0, io_rdata = 0. Reset overrides flush, writes and reads. Reset mid-operation discards all contents within the same cycle.
- All status outputs are functions of registered state only; there is no combinational path from io_wr_en or io_rd_en to any flag. A write at edge N shows in io_count and io_empty after edge N.
- Write-to-read latency: a word written at edge N can be popped at edge N+1. In standard mode it appears on io_rdata after the pop edge (N+2 at the earliest). In FWFT mode it is visible on io_rdata after edge N.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset, then 16 writes of 0x01..0x10, no reads -> io_full = 1 after the 16th edge, io_count = 16, io_almost_full rises after the 12th write, io_almost_empty falls after the 3rd write; a 17th write of 0xFF is dropped and sets io_overflow.
- Drain the full FIFO in standard mode -> io_rdata = 0x01..0x10 in order, each appearing one cycle after its pop with io_rvalid high; then io_empty = 1, and one extra read sets io_underflow with io_rdata holding 0x10.
- FWFT=1, write 0xA5 into an empty FIFO -> io_rdata = 0xA5 and io_rvalid = 1 the cycle after the write, with no read issued; pop -> io_empty = 1.
- Full FIFO with simultaneous wr_en = 1 and rd_en = 1 -> read accepted, write dropped, io_count = 15, io_overflow = 1. Empty FIFO with both requests -> write accepted, io_count = 1, io_underflow = 1.
- 40 cycles of continuous simultaneous read and write at count 5 (exercises pointer wrap) -> io_count stays 5 throughout and the data order is preserved.
- Flush asserted together with wr_en at count 9 -> io_count = 0, io_empty = 1, sticky flags unchanged; io_clr_err -> both error flags return to 0.
